memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage in the RV32IM 5-stage core.
- Consumes the ALU result as an effective address or pass-through value, and the forwarded rs2 as store data.
- Performs byte/half/word loads and stores against an internal synchronous data RAM, then presents a registered result to the MEM/WB boundary with a fixed 1-cycle latency.

---
 rtl/core_pkg.sv | 13 +
 rtl/memory_stage_if.sv | 33 +++
 rtl/data_ram.sv | 36 +++
 rtl/memory_stage.sv | 134 +++++++++++++
 tb/tb_memory_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, byte-lane count and memory func3 encodings.
package core_pkg;

    localparam int XLEN  = 32;
    localparam int LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/memory_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one bus.
interface memory_stage_if;
    import core_pkg::*;

    logic            in_valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [2:0]      func3;
    logic            mem_read;
    logic            mem_write;
    logic [4:0]      rd;
    logic            reg_write;
    logic            stall;

    logic            wb_valid;
    logic [XLEN-1:0] wb_result;
    logic [4:0]      wb_rd;
    logic            wb_reg_write;
    logic            mem_fault;

    modport master (
        output in_valid, alu_result, store_data, func3, mem_read, mem_write,
               rd, reg_write, stall,
        input  wb_valid, wb_result, wb_rd, wb_reg_write, mem_fault
    );

    modport slave (
        input  in_valid, alu_result, store_data, func3, mem_read, mem_write,
               rd, reg_write, stall,
        output wb_valid, wb_result, wb_rd, wb_reg_write, mem_fault
    );

endinterface

// File: rtl/data_ram.sv
// Single-port data RAM: per-byte-lane write enables, registered read gated by re.
module data_ram
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 re,
    input  logic [LANES-1:0]     we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [XLEN-1:0]      wdata,
    output logic [XLEN-1:0]      rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // One byte-wide array per lane keeps each lane a plain inferred RAM.
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    rd_byte_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: rtl/memory_stage.sv
// RV32IM memory stage: alignment check, lane-steered stores, synchronous loads with
// extension, and a registered MEM/WB slot with one cycle of latency.
module memory_stage
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);

    logic                 accept;
    logic [1:0]           addr_lo;
    logic                 width_ok;
    logic                 aligned;
    logic                 fault;
    logic                 do_load;
    logic                 do_store;
    logic [LANES-1:0]     lane_mask;
    logic [XLEN-1:0]      lane_data;
    logic [LANES-1:0]     ram_we;
    logic                 ram_re;
    logic [XLEN-1:0]      ram_rdata;

    logic                 valid_reg;
    logic                 reg_write_reg;
    logic                 fault_reg;
    logic [4:0]           rd_reg;
    logic [XLEN-1:0]      pass_reg;
    logic                 load_reg;
    logic [1:0]           lane_reg;
    logic [2:0]           func3_reg;
    logic [XLEN-1:0]      load_value;

    assign accept  = ~rst & ~bus.stall;
    assign addr_lo = bus.alu_result[1:0];

    // Unsigned widths exist only for loads; anything else in func3 is illegal.
    always_comb begin
        width_ok = 1'b0;
        aligned  = 1'b0;
        case (bus.func3)
            F3_B:  begin width_ok = 1'b1;          aligned = 1'b1;           end
            F3_H:  begin width_ok = 1'b1;          aligned = ~addr_lo[0];    end
            F3_W:  begin width_ok = 1'b1;          aligned = (addr_lo == 2'b00); end
            F3_BU: begin width_ok = bus.mem_read;  aligned = 1'b1;           end
            F3_HU: begin width_ok = bus.mem_read;  aligned = ~addr_lo[0];    end
            default: ;
        endcase
    end

    assign fault = bus.in_valid & (bus.mem_read | bus.mem_write) &
                   ((bus.mem_read & bus.mem_write) | ~width_ok | ~aligned);
    assign do_load  = bus.in_valid & bus.mem_read  & ~fault;
    assign do_store = bus.in_valid & bus.mem_write & ~fault;

    always_comb begin
        lane_mask = {LANES{1'b1}};
        lane_data = bus.store_data;
        case (bus.func3)
            F3_B: begin
                lane_mask = 4'b0001 << addr_lo;
                lane_data = {4{bus.store_data[7:0]}};
            end
            F3_H: begin
                lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ram_we = (accept & do_store) ? lane_mask : '0;
    assign ram_re = accept & do_load;

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (ADDR_BITS)
    ) u_data_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (bus.alu_result[ADDR_BITS+1:2]),
        .wdata (lane_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
            fault_reg     <= 1'b0;
            rd_reg        <= '0;
            pass_reg      <= '0;
            load_reg      <= 1'b0;
            lane_reg      <= '0;
            func3_reg     <= '0;
        end else if (!bus.stall) begin
            valid_reg     <= bus.in_valid;
            reg_write_reg <= bus.in_valid & bus.reg_write & ~fault & ~bus.mem_write;
            fault_reg     <= fault;
            rd_reg        <= bus.rd;
            pass_reg      <= fault ? '0 : bus.alu_result;
            load_reg      <= do_load;
            lane_reg      <= addr_lo;
            func3_reg     <= bus.func3;
        end
    end

    // Load data is formatted after the RAM register so the read stays a pure block RAM.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel   = ram_rdata[{lane_reg, 3'b000} +: 8];
        half_sel   = lane_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_value = ram_rdata;
        case (func3_reg)
            F3_B:  load_value = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: load_value = {24'd0, byte_sel};
            F3_H:  load_value = {{16{half_sel[15]}}, half_sel};
            F3_HU: load_value = {16'd0, half_sel};
            default: ;
        endcase
    end

    assign bus.wb_valid     = valid_reg;
    assign bus.wb_result    = load_reg ? load_value : pass_reg;
    assign bus.wb_rd        = rd_reg;
    assign bus.wb_reg_write = reg_write_reg;
    assign bus.mem_fault    = fault_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a byte-array reference model predicts each slot.
module tb_memory_stage;
    import core_pkg::*;

    localparam int DEPTH_WORDS = 1024;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;

    typedef struct {
        logic        in_valid;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic [4:0]  rd;
        logic        rw;
    } txn_t;

    typedef struct {
        logic        valid;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
        logic        fault;
        bit          chk_res;
        bit          chk_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_stage_if bus ();

    memory_stage #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_txn  = 0;
    logic [7:0]  mdl [MEM_BYTES];
    exp_t        sb_q [$];

    // Reference: little-endian byte memory, address taken modulo the RAM size.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          size;
        bit          sgn;
        bit          ld_only;
        bit          legal;
        int          base;
        logic [31:0] val;
        e = '{valid: t.in_valid, result: 32'd0, rd: t.rd, rw: 1'b0, fault: 1'b0,
               chk_res: 1'b1, chk_rd: 1'b1};
        if (!t.in_valid) begin
            e.chk_res = 1'b0;
            e.chk_rd  = 1'b0;
            return e;
        end
        if (!(t.mr || t.mw)) begin
            e.result = t.alu;
            e.rw     = t.rw;
            return e;
        end
        size = 0; sgn = 1'b0; ld_only = 1'b0;
        case (t.f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd4: begin size = 1; ld_only = 1'b1; end
            3'd5: begin size = 2; ld_only = 1'b1; end
            default: size = 0;
        endcase
        legal = (size != 0) && !(t.mr && t.mw) && !(t.mw && ld_only) &&
                ((t.alu % size) == 0);
        if (!legal) begin
            e.fault = 1'b1;
            return e;
        end
        base = int'(t.alu % MEM_BYTES);
        if (t.mw) begin
            for (int i = 0; i < size; i++) mdl[base + i] = 8'(t.sd >> (8 * i));
            e.chk_res = 1'b0;
            return e;
        end
        val = 32'd0;
        for (int i = 0; i < size; i++) val = val | ({24'd0, mdl[base + i]} << (8 * i));
        if (sgn && size < 4 && val[8 * size - 1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
        e.result = val;
        e.rw     = t.rw;
        return e;
    endfunction

    function automatic txn_t mk_alu(input logic [31:0] v, input logic [4:0] rd);
        return '{in_valid: 1'b1, alu: v, sd: $urandom, f3: 3'($urandom), mr: 1'b0,
                 mw: 1'b0, rd: rd, rw: 1'b1};
    endfunction

    function automatic txn_t mk_ld(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
        return '{in_valid: 1'b1, alu: a, sd: $urandom, f3: f3, mr: 1'b1,
                 mw: 1'b0, rd: rd, rw: 1'b1};
    endfunction

    function automatic txn_t mk_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        return '{in_valid: 1'b1, alu: a, sd: d, f3: f3, mr: 1'b0,
                 mw: 1'b1, rd: 5'($urandom), rw: 1'b0};
    endfunction

    function automatic txn_t mk_bubble();
        return '{in_valid: 1'b0, alu: $urandom, sd: $urandom, f3: 3'($urandom),
                 mr: 1'($urandom), mw: 1'($urandom), rd: 5'($urandom), rw: 1'b1};
    endfunction

    task automatic drive(input txn_t t, input bit st, input bit r);
        exp_t e;
        bus.in_valid   = t.in_valid;
        bus.alu_result = t.alu;
        bus.store_data = t.sd;
        bus.func3      = t.f3;
        bus.mem_read   = t.mr;
        bus.mem_write  = t.mw;
        bus.rd         = t.rd;
        bus.reg_write  = t.rw;
        bus.stall      = st;
        rst            = r;
        if (r) begin
            e = '{valid: 1'b0, result: 32'd0, rd: 5'd0, rw: 1'b0, fault: 1'b0,
                  chk_res: 1'b1, chk_rd: 1'b1};
            sb_q.push_back(e);
        end else if (!st) begin
            sb_q.push_back(model(t));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check_slot(input exp_t e, input string ph);
        chk({ph, "_valid"}, {31'd0, bus.wb_valid}, {31'd0, e.valid});
        chk({ph, "_reg_write"}, {31'd0, bus.wb_reg_write}, {31'd0, e.rw});
        chk({ph, "_fault"}, {31'd0, bus.mem_fault}, {31'd0, e.fault});
        if (e.chk_res) chk({ph, "_result"}, bus.wb_result, e.result);
        if (e.chk_rd)  chk({ph, "_rd"}, {27'd0, bus.wb_rd}, {27'd0, e.rd});
    endtask

    // Monitor: every accepting edge yields one new slot; stalled edges must hold it.
    initial begin
        exp_t cur;
        bit   acc;
        bit   have;
        have = 1'b0;
        forever begin
            @(posedge clk);
            acc = rst || !bus.stall;
            @(negedge clk);
            if (acc) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue want entry (t=%0t)", $time);
                end else begin
                    cur  = sb_q.pop_front();
                    have = 1'b1;
                    n_txn++;
                    check_slot(cur, "out");
                    $display("txn %0d: valid=%0b result=%h rd=%0d rw=%0b fault=%0b", n_txn,
                             bus.wb_valid, bus.wb_result, bus.wb_rd, bus.wb_reg_write, bus.mem_fault);
                end
            end else if (have) begin
                check_slot(cur, "hold");
            end
        end
    end

    initial begin
        txn_t t;
        int   kind;
        logic [31:0] a;
        drive(mk_bubble(), 1'b0, 1'b1);
        drive(mk_bubble(), 1'b0, 1'b1);

        for (int w = 0; w < 64; w++) drive(mk_st(w * 4, $urandom, F3_W), 1'b0, 1'b0);

        drive(mk_st(32'h10, 32'hDEADBEEF, F3_W), 1'b0, 1'b0);
        drive(mk_ld(32'h10, F3_W, 5'd5), 1'b0, 1'b0);

        drive(mk_st(32'h20, 32'h0, F3_W), 1'b0, 1'b0);
        drive(mk_st(32'h21, 32'h80, F3_B), 1'b0, 1'b0);
        drive(mk_ld(32'h21, F3_B, 5'd1), 1'b0, 1'b0);
        drive(mk_ld(32'h21, F3_BU, 5'd2), 1'b0, 1'b0);
        drive(mk_ld(32'h20, F3_W, 5'd3), 1'b0, 1'b0);

        drive(mk_st(32'h32, 32'h8001, F3_H), 1'b0, 1'b0);
        drive(mk_ld(32'h32, F3_H, 5'd4), 1'b0, 1'b0);
        drive(mk_ld(32'h32, F3_HU, 5'd6), 1'b0, 1'b0);
        drive(mk_ld(32'h31, F3_H, 5'd8), 1'b0, 1'b0);

        drive(mk_st(32'h40, 32'h12345678, F3_W), 1'b0, 1'b0);
        drive(mk_st(32'h42, 32'hFFFFFFFF, F3_W), 1'b0, 1'b0);
        drive(mk_ld(32'h40, F3_W, 5'd10), 1'b0, 1'b0);

        drive(mk_alu(32'h55, 5'd7), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(mk_ld(32'h40, F3_W, 5'd9), 1'b1, 1'b0);
        drive(mk_ld(32'h40, F3_W, 5'd9), 1'b0, 1'b0);

        drive(mk_st(32'h80, 32'hAAAA5555, F3_W), 1'b0, 1'b1);
        drive(mk_ld(32'h80, F3_W, 5'd11), 1'b0, 1'b0);

        // Address wrap, illegal encodings and x0 pass-through.
        drive(mk_st(32'h1044, 32'hCAFEF00D, F3_W), 1'b0, 1'b0);
        drive(mk_ld(32'h44, F3_W, 5'd12), 1'b0, 1'b0);
        drive(mk_ld(32'h44, 3'b011, 5'd13), 1'b0, 1'b0);
        drive(mk_st(32'h44, 32'h0, F3_BU), 1'b0, 1'b0);
        t = mk_st(32'h44, 32'h0, F3_W);
        t.mr = 1'b1;
        drive(t, 1'b0, 1'b0);
        drive(mk_ld(32'h44, F3_W, 5'd14), 1'b0, 1'b0);
        drive(mk_alu(32'h1234, 5'd0), 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3) + ($urandom_range(0, 3) << 12));
            kind = $urandom_range(0, 99);
            if (kind < 40)      t = mk_ld(a, 3'($urandom), 5'($urandom));
            else if (kind < 70) t = mk_st(a, $urandom, 3'($urandom));
            else if (kind < 88) t = mk_alu($urandom, 5'($urandom));
            else if (kind < 96) t = mk_bubble();
            else begin
                t = mk_st(a, $urandom, 3'($urandom));
                t.mr = 1'b1;
            end
            t.rw = (kind < 70) ? 1'($urandom) | (kind < 40 ? 1'b1 : 1'b0) : t.rw;
            drive(t, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 2));
        end

        for (int i = 0; i < 3; i++) drive(mk_bubble(), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
